sar_result_averager: RTL and testbench

// - Conversion controller and result consumer for the SAR ADC; sits directly downstream of sar_adc.
// - On a start pulse, drives the ADC hold input for 2**LOG2_AVG back-to-back conversions.
// - Captures each result on the rising edge of eoc and accumulates it.
// - Presents the floor-average on a valid/ready output port.

---
 rtl/sar_pkg.sv | 13 +
 rtl/sar_eoc_edge_det.sv | 23 ++
 rtl/sar_result_averager.sv | 171 +++++++++++++++++
 tb/tb_sar_result_averager.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC result path.
package sar_pkg;

    localparam int unsigned SAR_NBITS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } sar_avg_state_t;

endpackage : sar_pkg

// File: rtl/sar_eoc_edge_det.sv
// Rising-edge detector for the SAR ADC end-of-conversion strobe.
// Shared by every block that consumes eoc.
module sar_eoc_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic eoc_i,
    output logic eoc_rise_c_o
);

    logic eoc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eoc_q <= 1'b0;
        end else begin
            eoc_q <= eoc_i;
        end
    end

    // A level that was already high in the previous cycle is not an edge.
    assign eoc_rise_c_o = eoc_i & ~eoc_q;

endmodule : sar_eoc_edge_det

// File: rtl/sar_result_averager.sv
// SAR ADC conversion controller: runs 2**LOG2_AVG conversions per start and
// presents the floor-average on a valid/ready port. Optional conversion
// timeout is enabled with the SAR_AVG_TIMEOUT_EN macro.
module sar_result_averager
    import sar_pkg::*;
#(
    parameter int unsigned N_BITS         = SAR_NBITS_DEFAULT,
    parameter int unsigned LOG2_AVG       = 2,
    parameter int unsigned RELEASE_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              adc_hold,
    input  logic              adc_eoc,
    input  logic [N_BITS-1:0] adc_result,
    output logic [N_BITS-1:0] avg_data,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned ACC_W = N_BITS + LOG2_AVG;
    localparam int unsigned CNT_W = LOG2_AVG + 1;
    localparam int unsigned AVG_N = 2 ** LOG2_AVG;
    localparam int unsigned GAP_W = $clog2(RELEASE_CYCLES + 1);

    if (RELEASE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_chk
        $error("sar_result_averager: RELEASE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    sar_avg_state_t    state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_inc;
    logic [N_BITS-1:0] avg_data_q, avg_data_d;
    logic              adc_hold_q;
    logic              avg_valid_q;
    logic              busy_q;
    logic              eoc_rise;

`ifdef SAR_AVG_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             terr_q, terr_d;
`endif

    sar_eoc_edge_det u_eoc_edge (
        .clk          (clk),
        .reset        (reset),
        .eoc_i        (adc_eoc),
        .eoc_rise_c_o (eoc_rise)
    );

    // Gap counter saturates so a long eoc-high period cannot wrap it.
    assign gap_inc = (gap_q == GAP_W'(RELEASE_CYCLES)) ? gap_q : gap_q + GAP_W'(1);

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        avg_data_d = avg_data_q;
`ifdef SAR_AVG_TIMEOUT_EN
        tmo_d      = tmo_q;
        terr_d     = terr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONVERT;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef SAR_AVG_TIMEOUT_EN
                    tmo_d   = '0;
                    terr_d  = 1'b0;
`endif
                end
            end
            CONVERT: begin
`ifdef SAR_AVG_TIMEOUT_EN
                tmo_d = tmo_q + TMO_W'(1);
`endif
                if (eoc_rise) begin
                    acc_d   = acc_q + ACC_W'(adc_result);
                    cnt_d   = cnt_q + CNT_W'(1);
                    gap_d   = '0;
                    state_d = RELEASE;
                end
`ifdef SAR_AVG_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end
`endif
            end
            RELEASE: begin
                gap_d = gap_inc;
                // Hold stays low until eoc has dropped and the minimum gap has elapsed.
                if (!adc_eoc && (gap_inc >= GAP_W'(RELEASE_CYCLES))) begin
                    if (cnt_q == CNT_W'(AVG_N)) begin
                        state_d    = DONE;
                        avg_data_d = N_BITS'(acc_q >> LOG2_AVG);
                    end else begin
                        state_d = CONVERT;
`ifdef SAR_AVG_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            DONE: begin
                if (avg_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            avg_data_q  <= '0;
            adc_hold_q  <= 1'b0;
            avg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            avg_data_q  <= avg_data_d;
            adc_hold_q  <= (state_d == CONVERT);
            avg_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

`ifdef SAR_AVG_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign adc_hold  = adc_hold_q;
    assign avg_data  = avg_data_q;
    assign avg_valid = avg_valid_q;
    assign busy      = busy_q;

endmodule : sar_result_averager

// File: tb/tb_sar_result_averager.sv
// Bench for sar_result_averager: the bench plays the ADC and the consumer,
// expected averages come from plain arithmetic on the samples it sends.
module tb_sar_result_averager;

    localparam int unsigned NB  = 10;
    localparam int unsigned L2  = 2;
    localparam int unsigned RC  = 2;
    localparam int unsigned TMO = 64;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          start  = 1'b0;
    logic          eoc    = 1'b0;
    logic          ready  = 1'b0;
    logic [NB-1:0] result = '0;
    logic          hold, valid, busy, terr;
    logic [NB-1:0] data;

    logic          start_b  = 1'b0;
    logic          eoc_b    = 1'b0;
    logic          ready_b  = 1'b0;
    logic [NB-1:0] result_b = '0;
    logic          hold_b, valid_b, busy_b, terr_b;
    logic [NB-1:0] data_b;

    int n_vec = 0;
    int n_err = 0;
    int vals  [4];
    int highs [4];

    sar_result_averager #(
        .N_BITS(NB), .LOG2_AVG(L2), .RELEASE_CYCLES(RC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .adc_hold(hold), .adc_eoc(eoc),
        .adc_result(result), .avg_data(data), .avg_valid(valid), .avg_ready(ready),
        .busy(busy), .timeout_err(terr)
    );

    sar_result_averager #(
        .N_BITS(NB), .LOG2_AVG(0), .RELEASE_CYCLES(RC), .TIMEOUT_CYCLES(TMO)
    ) dut_single (
        .clk(clk), .reset(reset), .start(start_b), .adc_hold(hold_b), .adc_eoc(eoc_b),
        .adc_result(result_b), .avg_data(data_b), .avg_valid(valid_b), .avg_ready(ready_b),
        .busy(busy_b), .timeout_err(terr_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One conversion on the main instance; hold must already be high on entry.
    task automatic convert_one(input int v, input int h, input bit last, input int exp);
        int d;
        int lat;
        d = $urandom_range(0, 3);
        chk1("hold_in_convert", hold, 1'b1);
        repeat (d) begin
            tick();
            chk1("hold_wait_eoc", hold, 1'b1);
        end
        eoc    = 1'b1;
        result = NB'(v);
        tick();
        result = NB'($urandom_range(0, 1023));
        chk1("hold_drop_on_eoc", hold, 1'b0);
        lat = (h > int'(RC)) ? h : int'(RC);
        for (int s = 1; s <= lat; s++) begin
            if (s == h) eoc = 1'b0;
            tick();
            if (s < lat) begin
                chk1("release_hold_low", hold, 1'b0);
                chk1("release_no_valid", valid, 1'b0);
            end
        end
        if (last) begin
            chk1("done_valid", valid, 1'b1);
            chkd("done_data", data, NB'(exp));
            chk1("done_busy", busy, 1'b1);
            chk1("done_hold_low", hold, 1'b0);
        end else begin
            chk1("next_hold_high", hold, 1'b1);
            chk1("next_no_valid", valid, 1'b0);
        end
    endtask

    // Full burst from vals/highs, consumer waits rdy_wait cycles, optionally poking start.
    task automatic run_burst(input int rdy_wait, input bit poke);
        int sum;
        int exp;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += vals[i];
        exp = sum / 4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("start_hold_rise", hold, 1'b1);
        chk1("start_busy", busy, 1'b1);
        chk1("start_terr_clear", terr, 1'b0);
        for (int i = 0; i < 4; i++) convert_one(vals[i], highs[i], i == 3, exp);
        for (int k = 0; k < rdy_wait; k++) begin
            start = poke && (k == rdy_wait / 2);
            tick();
            start = 1'b0;
            chk1("wait_valid_held", valid, 1'b1);
            chkd("wait_data_stable", data, NB'(exp));
            chk1("wait_start_ignored", hold, 1'b0);
        end
        ready = 1'b1;
        start = poke;
        tick();
        ready = 1'b0;
        start = 1'b0;
        chk1("accept_valid_drop", valid, 1'b0);
        chk1("accept_idle", busy, 1'b0);
        chkd("accept_data_kept", data, NB'(exp));
        tick();
        chk1("post_accept_idle", busy, 1'b0);
        chk1("post_accept_hold", hold, 1'b0);
    endtask

    initial begin
        int pulses;
        int cnt;
        int v1;

        repeat (3) tick();
        chk1("rst_hold", hold, 1'b0);
        chkd("rst_data", data, '0);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_terr", terr, 1'b0);
        chk1("rst_b_hold", hold_b, 1'b0);
        chk1("rst_b_valid", valid_b, 1'b0);
        chk1("rst_b_busy", busy_b, 1'b0);
        reset = 1'b0;
        tick();
        chk1("idle_hold", hold, 1'b0);

        // Directed burst: 100,101,102,104 -> 407/4 = 101; consumer stalls 10 cycles.
        vals  = '{100, 101, 102, 104};
        highs = '{1, 2, 3, 1};
        run_burst(10, 1'b1);

        // Long eoc-high pulses must each be accumulated once.
        for (int i = 0; i < 4; i++) vals[i] = $urandom_range(0, 1023);
        highs = '{6, 1, 6, 2};
        run_burst(0, 1'b0);

        // Extremes.
        vals  = '{1023, 1023, 1023, 1023};
        highs = '{1, 1, 1, 1};
        run_burst(1, 1'b0);
        vals  = '{0, 0, 0, 3};
        run_burst(2, 1'b1);

        repeat (6) begin
            for (int i = 0; i < 4; i++) begin
                vals[i]  = $urandom_range(0, 1023);
                highs[i] = $urandom_range(1, 6);
            end
            run_burst($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Single-shot instance: one conversion is the whole average.
        for (int r = 0; r < 2; r++) begin
            v1 = (r == 0) ? 1023 : int'($urandom_range(0, 1023));
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            chk1("single_hold_rise", hold_b, 1'b1);
            eoc_b    = 1'b1;
            result_b = NB'(v1);
            tick();
            eoc_b    = 1'b0;
            result_b = '0;
            chk1("single_hold_drop", hold_b, 1'b0);
            tick();
            chk1("single_no_valid_yet", valid_b, 1'b0);
            tick();
            chk1("single_valid", valid_b, 1'b1);
            chkd("single_data", data_b, NB'(v1));
            pulses = 0;
            repeat (5) begin
                tick();
                if (hold_b) pulses++;
            end
            chkd("single_one_pulse", NB'(pulses), '0);
            ready_b = 1'b1;
            tick();
            ready_b = 1'b0;
            chk1("single_accept", valid_b, 1'b0);
            chk1("single_idle", busy_b, 1'b0);
        end

        // Reset in the middle of the third conversion.
        for (int i = 0; i < 4; i++) vals[i] = $urandom_range(0, 1023);
        start = 1'b1;
        tick();
        start = 1'b0;
        convert_one(vals[0], 1, 1'b0, 0);
        convert_one(vals[1], 2, 1'b0, 0);
        tick();
        #2 reset = 1'b1;
        #1;
        chk1("midrst_hold", hold, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_valid", valid, 1'b0);
        chkd("midrst_data", data, '0);
        chk1("midrst_terr", terr, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk1("postrst_idle", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            vals[i]  = $urandom_range(0, 1023);
            highs[i] = $urandom_range(1, 3);
        end
        run_burst(1, 1'b0);

`ifdef SAR_AVG_TIMEOUT_EN
        // eoc never arrives: hold high for TMO cycles, then sticky error and IDLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (hold && cnt < 200) begin
            cnt++;
            tick();
        end
        chkd("tmo_hold_cycles", NB'(cnt), NB'(TMO));
        chk1("tmo_err_set", terr, 1'b1);
        chk1("tmo_idle", busy, 1'b0);
        chk1("tmo_no_valid", valid, 1'b0);
        repeat (3) tick();
        chk1("tmo_err_sticky", terr, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("tmo_err_cleared", terr, 1'b0);
        chk1("tmo_restart_hold", hold, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`else
        cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) begin
            tick();
            if (hold) cnt++;
        end
        chkd("no_tmo_waits", NB'(cnt), NB'(100));
        chk1("no_tmo_err", terr, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sar_result_averager
